// File: rtl/freq_meas_scheduler_pkg.sv
// Shared definitions for the frequency-measurement scheduler.
// Contents: FSM state encodings, channel-count limit, and the round-robin
// helper that finds the next enabled channel after a given pointer.
package freq_meas_scheduler_pkg;

    localparam int unsigned MAX_CH = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_GATE   = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    // First enabled index strictly after ptr, wrapping modulo num_ch.
    // Returns ptr unchanged when nothing is enabled; callers gate on |enable.
    function automatic logic [2:0] next_rr(input logic [2:0]        ptr,
                                           input logic [MAX_CH-1:0] enable,
                                           input int unsigned       num_ch);
        logic [2:0] idx;
        logic       found;
        next_rr = ptr;
        found   = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = 3'((32'(ptr) + i) % num_ch);
            if (i <= num_ch && !found && enable[idx]) begin
                next_rr = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/freq_meas_scheduler_if.sv
// Bus between the scheduler and its environment.
// slave  : scheduler side (takes sig_in/ch_enable/run/result_ready,
//          drives result/result_ch/result_sat/result_valid/busy).
// master : environment side, directions mirrored.
interface freq_meas_scheduler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] sig_in;
    logic [NUM_CH-1:0] ch_enable;
    logic              run;
    logic [CNT_W-1:0]  result;
    logic [CH_W-1:0]   result_ch;
    logic              result_sat;
    logic              result_valid;
    logic              result_ready;
    logic              busy;

    modport master (
        output sig_in, ch_enable, run, result_ready,
        input  result, result_ch, result_sat, result_valid, busy
    );

    modport slave (
        input  sig_in, ch_enable, run, result_ready,
        output result, result_ch, result_sat, result_valid, busy
    );
endinterface

// File: rtl/freq_gate_counter.sv
// Saturating rising-edge counter used inside one gate window.
// Ports: clk, rst_n (async active-low), clear (sync clear), enable (gate open),
//        edge_in (one-cycle edge strobe), count (current count), sat (an edge
//        arrived while the count was already at its maximum).
module freq_gate_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             edge_in,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    // Count edges while enabled; pin at all-ones and flag the lost edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (enable && edge_in) begin
            if (count == '1) begin
                sat <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/freq_meas_scheduler.sv
// Time-shares one gated edge counter across NUM_CH square-wave inputs.
// Round-robin picks an enabled channel, settles, counts rising edges for
// GATE_CYCLES clocks and presents a channel-tagged result on valid/ready.
// Ports: clk, rst_n (async assert, synchronised deassert),
//        bus (slave modport): sig_in, ch_enable, run, result_ready in;
//        result, result_ch, result_sat, result_valid, busy out (registered).
module freq_meas_scheduler
    import freq_meas_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_CYCLES   = 3437500,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    freq_meas_scheduler_if.slave bus
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);

    logic [1:0]        rst_pipe;
    logic              rst_sync_n;
    logic [NUM_CH-1:0] sync1, sync2;
    logic              prev;
    logic              sel_sync, edge_det;

    logic [2:0]        state, state_nxt;
    logic [CH_W-1:0]   cur_ch, cur_ch_nxt;
    logic [CH_W-1:0]   rr, rr_nxt, pick;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [CNT_W-1:0]  res, res_nxt;
    logic [CH_W-1:0]   res_ch, res_ch_nxt;
    logic              res_sat, res_sat_nxt;
    logic              res_valid, res_valid_nxt;
    logic              busy_q, busy_nxt;

    logic              cnt_clear, cnt_en;
    logic [CNT_W-1:0]  gc_count;
    logic              gc_sat, gc_full;
    logic [CNT_W-1:0]  final_cnt;
    logic              final_sat;

    // Reset asserts asynchronously, releases two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    // Two-flop synchronisers plus edge-detect history on the selected channel.
    // prev always follows the selected input, so a channel switch is absorbed in SETTLE.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.sig_in;
            sync2 <= sync1;
            prev  <= sel_sync;
        end
    end

    assign sel_sync = sync2[cur_ch];
    assign edge_det = sel_sync & ~prev;

    assign cnt_clear = (state == ST_IDLE) || (state == ST_SELECT);
    assign cnt_en    = (state == ST_GATE);

    freq_gate_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_sync_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .edge_in (edge_det),
        .count   (gc_count),
        .sat     (gc_sat)
    );

    // Value the counter will hold after the last gate cycle, edge included.
    assign gc_full   = (gc_count == '1);
    assign final_cnt = (edge_det && !gc_full) ? gc_count + CNT_W'(1) : gc_count;
    assign final_sat = gc_sat | (edge_det & gc_full);

    assign pick = CH_W'(next_rr(3'(rr), MAX_CH'(bus.ch_enable), NUM_CH));

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_IDLE;
            cur_ch    <= '0;
            rr        <= CH_W'(NUM_CH - 1);
            tmr       <= '0;
            res       <= '0;
            res_ch    <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_ch    <= cur_ch_nxt;
            rr        <= rr_nxt;
            tmr       <= tmr_nxt;
            res       <= res_nxt;
            res_ch    <= res_ch_nxt;
            res_sat   <= res_sat_nxt;
            res_valid <= res_valid_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cur_ch_nxt    = cur_ch;
        rr_nxt        = rr;
        tmr_nxt       = tmr;
        res_nxt       = res;
        res_ch_nxt    = res_ch;
        res_sat_nxt   = res_sat;
        res_valid_nxt = res_valid;

        case (state)
            ST_IDLE: begin
                if (bus.run && (|bus.ch_enable)) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (!(|bus.ch_enable)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cur_ch_nxt = pick;
                    rr_nxt     = pick;
                    tmr_nxt    = TMR_W'(SETTLE_CYCLES - 1);
                    state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!bus.run) begin
                    state_nxt = ST_IDLE;
                end else if (!bus.ch_enable[cur_ch]) begin
                    state_nxt = ST_SELECT;
                end else if (tmr == '0) begin
                    tmr_nxt   = TMR_W'(GATE_CYCLES - 1);
                    state_nxt = ST_GATE;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_GATE: begin
                if (!bus.run) begin
                    state_nxt = ST_IDLE;
                end else if (!bus.ch_enable[cur_ch]) begin
                    state_nxt = ST_SELECT;
                end else if (tmr == '0) begin
                    res_nxt       = final_cnt;
                    res_sat_nxt   = final_sat;
                    res_ch_nxt    = cur_ch;
                    res_valid_nxt = 1'b1;
                    state_nxt     = ST_REPORT;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_REPORT: begin
                // run/ch_enable are ignored until the result is taken.
                if (bus.result_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = bus.run ? ST_SELECT : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus.result       = res;
    assign bus.result_ch    = res_ch;
    assign bus.result_sat   = res_sat;
    assign bus.result_valid = res_valid;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Directed bench for freq_meas_scheduler with a behavioural result model.
module tb_freq_meas_scheduler;

    localparam int unsigned GATE   = 100;
    localparam int unsigned SETTLE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    freq_meas_scheduler_if #(.NUM_CH(4), .CNT_W(16)) bus ();
    freq_meas_scheduler_if #(.NUM_CH(4), .CNT_W(4))  bus_s ();

    freq_meas_scheduler #(.NUM_CH(4), .CNT_W(16), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    freq_meas_scheduler #(.NUM_CH(4), .CNT_W(4), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    // Square-wave periods in clk cycles for ch0..ch3.
    int unsigned per [4] = '{10, 20, 6, 4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A gate of GATE cycles on an integer-period input sees GATE/period edges.
    function automatic int unsigned model_edges(input int ch);
        return GATE / per[ch];
    endfunction

    function automatic int unsigned model_count(input int ch, input int unsigned cw);
        int unsigned lim;
        lim = (32'd1 << cw) - 1;
        return (model_edges(ch) > lim) ? lim : model_edges(ch);
    endfunction

    function automatic logic model_sat(input int ch, input int unsigned cw);
        return model_edges(ch) > ((32'd1 << cw) - 1);
    endfunction

    // Input waveforms change on the falling edge; they are asynchronous to the DUT anyway.
    initial begin
        int unsigned ph [4];
        logic [3:0]  sig;
        for (int i = 0; i < 4; i++) ph[i] = 0;
        sig = '0;
        bus.sig_in   = '0;
        bus_s.sig_in = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                ph[i]  = (ph[i] + 1) % per[i];
                sig[i] = (ph[i] < per[i] / 2);
            end
            bus.sig_in   = sig;
            bus_s.sig_in = {3'b000, sig[3]};
        end
    end

    // Compare process: each new result against the expected channel order and
    // model count; held results must stay stable until accepted.
    initial begin
        bit              held;
        logic [15:0]     cap_res;
        logic [1:0]      cap_ch;
        logic            cap_sat;
        int              e;
        held = 1'b0;
        cap_res = '0;
        cap_ch = '0;
        cap_sat = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else if (bus.result_valid) begin
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: got ch %0d count %0d, expected no result",
                                 bus.result_ch, bus.result);
                    end else begin
                        e = exp_q.pop_front();
                        check("model_ch", 32'(bus.result_ch), e);
                        check("model_count", 32'(bus.result), model_count(e, 16));
                        check("model_sat", 32'(bus.result_sat), 32'(model_sat(e, 16)));
                    end
                    cap_res = bus.result;
                    cap_ch  = bus.result_ch;
                    cap_sat = bus.result_sat;
                    held    = 1'b1;
                end else begin
                    check("hold_result", 32'(bus.result), 32'(cap_res));
                    check("hold_ch", 32'(bus.result_ch), 32'(cap_ch));
                    check("hold_sat", 32'(bus.result_sat), 32'(cap_sat));
                end
                if (bus.result_ready) held = 1'b0;
            end else if (held) begin
                n_cmp++;
                n_fail++;
                $display("FAIL valid_dropped: got result_valid 0 before handshake, expected 1");
                held = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n, input string name);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bus.result_valid && n < 400);
        if (!bus.result_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no result_valid in %0d cycles, expected one", name, n);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_ch"}, 32'(bus.result_ch), 0);
        check({tag, "_sat"}, 32'(bus.result_sat), 0);
        check({tag, "_valid"}, 32'(bus.result_valid), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int lat;
        bus.ch_enable      = 4'b0001;
        bus.run            = 1'b0;
        bus.result_ready   = 1'b1;
        bus_s.ch_enable    = 4'b0001;
        bus_s.run          = 1'b0;
        bus_s.result_ready = 1'b1;

        // Reset state.
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(5);

        // Single channel, period 10: count 10, first valid 110 cycles after run.
        exp_q.push_back(0);
        bus.run = 1'b1;
        wait_valid(lat, "a");
        check("a_latency", 32'(lat), 110);
        check("a_result", 32'(bus.result), 10);
        check("a_ch", 32'(bus.result_ch), 0);
        check("a_sat", 32'(bus.result_sat), 0);
        bus.run = 1'b0;
        tick(3);
        check("a_idle_busy", 32'(bus.busy), 0);
        check("a_idle_valid", 32'(bus.result_valid), 0);

        // Enables 1011: order 0,1,3,0 with counts 10,5,25,10.
        pulse_reset();
        bus.ch_enable = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(0);
        bus.run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(lat, "b");
            check("b_period", 32'(lat), 110);
        end
        check("b_third_result", 32'(bus.result), 25);
        tick(1);
        bus.result_ready = 1'b0;

        // Fourth result held 50 cycles with ready low.
        wait_valid(lat, "b_hold");
        tick(50);
        check("b_hold_valid", 32'(bus.result_valid), 1);
        check("b_hold_result", 32'(bus.result), 10);
        check("b_hold_ch", 32'(bus.result_ch), 0);
        exp_q.push_back(1);
        bus.result_ready = 1'b1;
        wait_valid(lat, "b_next");
        check("b_next_latency", 32'(lat), 110);
        check("b_next_result", 32'(bus.result), 5);

        // Drop ch3 at gate cycle 40: ch3 gives nothing, ch0 follows directly.
        exp_q.push_back(0);
        tick(1);
        tick(49);
        bus.ch_enable = 4'b0011;
        wait_valid(lat, "c");
        check("c_latency", 32'(lat), 110);
        check("c_ch", 32'(bus.result_ch), 0);
        check("c_result", 32'(bus.result), 10);

        // Drop run inside a gate, then reset in the middle of SETTLE.
        tick(60);
        bus.run = 1'b0;
        tick(2);
        check("d_abort_busy", 32'(bus.busy), 0);
        check("d_abort_valid", 32'(bus.result_valid), 0);
        bus.run = 1'b1;
        tick(4);
        check("d_rerun_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("d_rst");
        bus.run = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);

        // Narrow counter: 25 edges into 4 bits saturates at 15.
        bus_s.run = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!bus_s.result_valid && lat < 400);
        check("s_valid", 32'(bus_s.result_valid), 1);
        check("s_latency", 32'(lat), 110);
        check("s_result", 32'(bus_s.result), model_count(3, 4));
        check("s_result_lit", 32'(bus_s.result), 15);
        check("s_sat", 32'(bus_s.result_sat), 1);
        check("s_ch", 32'(bus_s.result_ch), 0);
        bus_s.run = 1'b0;
        tick(3);

        check("exp_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
- Time-shares one gated edge counter across NUM_CH square-wave inputs on the Basys2 frequency-measurement path.
- Round-robin selects an enabled channel, settles, opens a fixed gate window, counts rising edges, then hands the result downstream on a valid/ready handshake.
- Downstream (averaging, display) consumes one channel-tagged result per measurement.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- CNT_W, 16, result width.
- GATE_CYCLES, 3437500, gate window length in clk cycles (55e6>>4); the sim bench overrides it.
- SETTLE_CYCLES, 8, cycles between channel switch and gate open (must be at least 3).

Ports:
- clk  in  1  system clock (pin B8 domain).
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  NUM_CH  raw asynchronous square-wave inputs.
- ch_enable  in  NUM_CH  per-channel enable for scheduling.
- run  in  1  level; 1 = keep measuring, 0 = stop.
- result  out  CNT_W  rising-edge count of the last gate.
- result_ch  out  CH_W  channel index of result.
- result_sat  out  1  count saturated during that gate.
- result_valid  out  1  result fields are valid.
- result_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE, result=0, result_ch=0, result_sat=0, result_valid=0, busy=0, rr pointer=NUM_CH-1, synchronizers cleared.
- Every sig_in bit passes a 2-flop synchronizer. A rising edge is sync==1 and prev==0, so there is one count per period, with no double counting.
- States:
  - IDLE: when run=1 and |ch_enable, go to SELECT.
  - SELECT (1 cycle): pick the first enabled channel after the rr pointer, wrapping modulo NUM_CH, and latch it as cur_ch.
    - If no channel is enabled, go to IDLE.
    - Otherwise update the rr pointer to cur_ch and go to SETTLE.
  - SETTLE: hold SETTLE_CYCLES cycles. The edge-detect prev register tracks the selected sync signal so no false edge appears at the switch. Then go to GATE.
  - GATE: exactly GATE_CYCLES cycles. The edge counter increments on each detected edge and saturates at 2^CNT_W-1, setting the sat flag.
    - On the last gate cycle, an edge is counted and then the count is captured into result/result_sat. result_ch=cur_ch and result_valid=1 on the next cycle, and the state goes to REPORT.
  - REPORT: hold all result fields stable while result_valid=1 and result_ready=0.
    - When result_valid and result_ready are both high in a cycle, result_valid drops the next cycle.
    - Then go to SELECT if run=1, else IDLE.
- Latency: the first result_valid comes 1 + SETTLE_CYCLES + GATE_CYCLES + 1 cycles after IDLE sees run=1.
- Abort rules, checked in SETTLE and GATE:
  - run=0: go to IDLE, counter cleared, no result, result_valid stays 0.
  - ch_enable[cur_ch]=0: go to SELECT, no result.
  - Both at once: run=0 takes priority.
- REPORT ignores run and ch_enable changes until the handshake completes. A result is never dropped.
- Single enabled channel: it is selected repeatedly. Enabled channels are served in strict round-robin order.
- result_ready asserted outside REPORT has no effect.
- Reset mid-operation: immediate return to the reset values, with no partial result.

Decomposition:
- freq_pkg:
  - state enum {IDLE, SELECT, SETTLE, GATE, REPORT}.
  - CH_W = max(1, $clog2(NUM_CH)).
  - Helper function next_rr(ptr, enable) returning the next enabled index.
- Sub-module freq_gate_counter:
  - Ports: clk, rst_n, clear, enable, edge_in, count[CNT_W], sat.
  - Saturating counter, cleared by the scheduler at SETTLE entry.
  - The scheduler owns all timing and the handshake.

Test Plan:
- GATE_CYCLES=100, SETTLE=8, ch0 period 10 clk, only ch0 enabled, run=1, ready=1 → result=10, result_ch=0, sat=0; first valid at cycle 110 after run.
- Enables 4'b1011, ch0/1/3 periods 10/20/4, ready=1 → result_ch order 0,1,3,0, results 10,5,25,10.
- CNT_W=4, GATE_CYCLES=100, period 4 → result=15, sat=1.
- Hold ready=0 for 50 cycles in REPORT → fields stable and valid stays 1; one transfer on ready, then the next channel is measured.
- Drop ch_enable[cur_ch] at gate cycle 40 → no valid; next enabled channel selected within 1 cycle.
- Drop run in GATE, then assert rst_n=0 mid-SETTLE on a rerun → IDLE, busy=0, result_valid=0, all outputs at reset values.
